// File: rtl/mkio_chan_arb.sv
// Dual-redundant bus channel arbiter: locks onto the channel carrying the live
// command stream, forwards its words and steers transmit words to that channel's encoder.
// Channel B is enabled only when MKIO_CHB_EN is defined; otherwise the block is A-only.
module mkio_chan_arb #(
    parameter int TO_CYC = 768
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        dec_valid_a,
    input  logic        dec_valid_b,
    input  logic        dec_cs_a,
    input  logic        dec_cs_b,
    input  logic        dec_err_a,
    input  logic        dec_err_b,
    input  logic [15:0] dec_data_a,
    input  logic [15:0] dec_data_b,
    output logic        core_valid,
    output logic        core_cs,
    output logic        core_err,
    output logic [15:0] core_data,
    output logic        core_chan,
    output logic        core_abort,
    input  logic        core_tx_req,
    input  logic        core_tx_cs,
    input  logic [15:0] core_tx_data,
    output logic        core_tx_done,
    output logic        enc_start_a,
    output logic        enc_start_b,
    output logic        enc_abort_a,
    output logic        enc_abort_b,
    output logic        enc_cs,
    output logic [15:0] enc_data,
    input  logic        enc_done_a,
    input  logic        enc_done_b,
    output logic        tx_inhibit_a,
    output logic        tx_inhibit_b
);

`ifdef MKIO_CHB_EN
    localparam bit CHB_EN = 1'b1;
`else
    localparam bit CHB_EN = 1'b0;
`endif

    localparam int              CW       = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(TO_CYC - 1);
    localparam logic [CW-1:0]   CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOCK = 2'd1,
        TX   = 2'd2
    } state_e;

    state_e         state_q, state_d;
    logic           chan_q, chan_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           armed_q;
    logic           enc_cs_q, enc_cs_d;
    logic [15:0]    enc_data_q, enc_data_d;

    logic           core_valid_q, core_valid_d;
    logic           core_cs_q, core_cs_d;
    logic           core_err_q, core_err_d;
    logic [15:0]    core_data_q, core_data_d;
    logic           core_abort_q, core_abort_d;
    logic           core_tx_done_q, core_tx_done_d;
    logic           enc_start_a_q, enc_start_a_d;
    logic           enc_start_b_q, enc_start_b_d;
    logic           enc_abort_a_q, enc_abort_a_d;
    logic           enc_abort_b_q, enc_abort_b_d;
    logic           tx_inh_a_q, tx_inh_a_d;
    logic           tx_inh_b_q, tx_inh_b_d;

    logic           fwd, fwd_b, abort, start, kill, done;
    logic           cmd_a, cmd_b, valid_b, done_b;
    logic           own_valid, own_done, other_cmd;

    // Channel B events are masked at the source so an A-only build never sees them.
    assign cmd_a     = dec_valid_a & dec_cs_a & ~dec_err_a;
    assign valid_b   = CHB_EN & dec_valid_b;
    assign cmd_b     = valid_b & dec_cs_b & ~dec_err_b;
    assign done_b    = CHB_EN & enc_done_b;
    assign own_valid = chan_q ? valid_b : dec_valid_a;
    assign own_done  = chan_q ? done_b : enc_done_a;
    assign other_cmd = chan_q ? cmd_a : cmd_b;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q        <= IDLE;
            chan_q         <= 1'b0;
            cnt_q          <= '0;
            armed_q        <= 1'b0;
            enc_cs_q       <= 1'b0;
            enc_data_q     <= '0;
            core_valid_q   <= 1'b0;
            core_cs_q      <= 1'b0;
            core_err_q     <= 1'b0;
            core_data_q    <= '0;
            core_abort_q   <= 1'b0;
            core_tx_done_q <= 1'b0;
            enc_start_a_q  <= 1'b0;
            enc_start_b_q  <= 1'b0;
            enc_abort_a_q  <= 1'b0;
            enc_abort_b_q  <= 1'b0;
            tx_inh_a_q     <= 1'b1;
            tx_inh_b_q     <= 1'b1;
        end else begin
            state_q        <= state_d;
            chan_q         <= chan_d;
            cnt_q          <= cnt_d;
            armed_q        <= 1'b1;
            enc_cs_q       <= enc_cs_d;
            enc_data_q     <= enc_data_d;
            core_valid_q   <= core_valid_d;
            core_cs_q      <= core_cs_d;
            core_err_q     <= core_err_d;
            core_data_q    <= core_data_d;
            core_abort_q   <= core_abort_d;
            core_tx_done_q <= core_tx_done_d;
            enc_start_a_q  <= enc_start_a_d;
            enc_start_b_q  <= enc_start_b_d;
            enc_abort_a_q  <= enc_abort_a_d;
            enc_abort_b_q  <= enc_abort_b_d;
            tx_inh_a_q     <= tx_inh_a_d;
            tx_inh_b_q     <= tx_inh_b_d;
        end
    end

    // The first edge after reset release only arms the FSM; nothing moves until the second.
    always_comb begin
        state_d    = state_q;
        chan_d     = chan_q;
        cnt_d      = cnt_q;
        enc_cs_d   = enc_cs_q;
        enc_data_d = enc_data_q;
        fwd        = 1'b0;
        fwd_b      = 1'b0;
        abort      = 1'b0;
        start      = 1'b0;
        kill       = 1'b0;
        done       = 1'b0;
        if (armed_q) begin
            unique case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    if (cmd_a) begin
                        state_d = LOCK;
                        chan_d  = 1'b0;
                        fwd     = 1'b1;
                    end else if (cmd_b) begin
                        state_d = LOCK;
                        chan_d  = 1'b1;
                        fwd     = 1'b1;
                        fwd_b   = 1'b1;
                    end
                end
                LOCK: begin
                    if (other_cmd) begin
                        chan_d = ~chan_q;
                        fwd    = 1'b1;
                        fwd_b  = ~chan_q;
                        abort  = 1'b1;
                        cnt_d  = '0;
                    end else begin
                        if (own_valid) begin
                            fwd   = 1'b1;
                            fwd_b = chan_q;
                            cnt_d = '0;
                        end
                        if (core_tx_req) begin
                            start      = 1'b1;
                            enc_cs_d   = core_tx_cs;
                            enc_data_d = core_tx_data;
                            state_d    = TX;
                        end else if (!own_valid) begin
                            if (cnt_q == CNT_LAST) begin
                                state_d = IDLE;
                                cnt_d   = '0;
                            end else if (cnt_q != CNT_MAX) begin
                                cnt_d = cnt_q + 1'b1;
                            end
                        end
                    end
                end
                TX: begin
                    if (other_cmd) begin
                        kill    = 1'b1;
                        abort   = 1'b1;
                        chan_d  = ~chan_q;
                        fwd     = 1'b1;
                        fwd_b   = ~chan_q;
                        state_d = LOCK;
                        cnt_d   = '0;
                    end else if (own_done) begin
                        done    = 1'b1;
                        state_d = LOCK;
                        cnt_d   = '0;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        core_valid_d   = fwd;
        core_cs_d      = fwd & (fwd_b ? dec_cs_b : dec_cs_a);
        core_err_d     = fwd & (fwd_b ? dec_err_b : dec_err_a);
        core_data_d    = fwd ? (fwd_b ? dec_data_b : dec_data_a) : core_data_q;
        core_abort_d   = abort;
        core_tx_done_d = done;
        enc_start_a_d  = start & ~chan_q;
        enc_start_b_d  = start & chan_q;
        enc_abort_a_d  = kill & ~chan_q;
        enc_abort_b_d  = kill & chan_q;
        tx_inh_a_d     = !((state_d == TX) && !chan_d);
        tx_inh_b_d     = !((state_d == TX) && chan_d);
    end

    assign core_valid   = core_valid_q;
    assign core_cs      = core_cs_q;
    assign core_err     = core_err_q;
    assign core_data    = core_data_q;
    assign core_chan    = chan_q;
    assign core_abort   = core_abort_q;
    assign core_tx_done = core_tx_done_q;
    assign enc_cs       = enc_cs_q;
    assign enc_data     = enc_data_q;
    assign enc_start_a  = enc_start_a_q;
    assign enc_abort_a  = enc_abort_a_q;
    assign tx_inhibit_a = tx_inh_a_q;
    assign enc_start_b  = CHB_EN & enc_start_b_q;
    assign enc_abort_b  = CHB_EN & enc_abort_b_q;
    assign tx_inhibit_b = ~CHB_EN | tx_inh_b_q;

endmodule
